// File: rtl/ceil_div_iter.sv
// Iterative unsigned divider returning a floor or ceiled quotient plus the floor remainder.
// Latency: WIDTH+1 cycles from acceptance to result for a nonzero divisor; a zero divisor gives its result in the cycle right after acceptance.
// Backpressure: accepts one operation at a time in IDLE; holds the result in DONE until out_ready_i.
module ceil_div_iter #(
   parameter int WIDTH   = 32,
   parameter int CEIL_EN = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             mode_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_zero_o
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      ADJ  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_dvd;       // dividend bits shift out the top, quotient bits shift in the bottom
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH:0]   r_rem;       // one spare bit so the shifted remainder never overflows
   logic [CW-1:0]    r_cnt;
   logic             r_mode;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_remo;
   logic             r_dz;
   logic             r_ov;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_sub;
   logic             w_ge;
   logic             w_inc;
   logic             w_last;
   logic             w_mode_eff;

   // Trial subtraction for one restoring step plus rounding and mode decode.
   always_comb begin
      w_shift    = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
      w_ge       = (w_shift >= {1'b0, r_dvs});
      w_sub      = w_shift - {1'b0, r_dvs};
      // A nonzero remainder means divisor >= 2, so the increment cannot wrap.
      w_inc      = r_mode && (r_rem != '0);
      w_last     = (r_cnt == CW'(WIDTH - 1));
      w_mode_eff = (CEIL_EN != 0) ? mode_i : 1'b0;
   end

   // Control FSM and datapath; reset overrides every handshake.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_rem   <= '0;
         r_cnt   <= '0;
         r_mode  <= 1'b0;
         r_quo   <= '0;
         r_remo  <= '0;
         r_dz    <= 1'b0;
         r_ov    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid_i) begin
                  if (divisor_i == '0) begin
                     r_quo   <= '1;
                     r_remo  <= dividend_i;
                     r_dz    <= 1'b1;
                     r_ov    <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_dvd   <= dividend_i;
                     r_dvs   <= divisor_i;
                     r_rem   <= '0;
                     r_cnt   <= '0;
                     r_mode  <= w_mode_eff;
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               r_rem <= w_ge ? w_sub : w_shift;
               r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state <= ADJ;
               end
            end
            ADJ: begin
               r_quo   <= r_dvd + {{(WIDTH-1){1'b0}}, w_inc};
               r_remo  <= r_rem[WIDTH-1:0];
               r_dz    <= 1'b0;
               r_ov    <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               if (out_ready_i) begin
                  r_ov    <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready_o  = (r_state == IDLE);
   assign out_valid_o = r_ov;
   assign quotient_o  = r_quo;
   assign remainder_o = r_remo;
   assign div_zero_o  = r_dz;

endmodule

// File: doc/ceil_div_iter.md
CEIL_DIV_ITER -- requirements
Module: ceil_div_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits, legal range 2..64.
REQ-002 SHALL have parameter CEIL_EN, default 1: 1 = mode_i honoured; 0 = mode_i ignored and floor division always performed.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid_i  input  1  operand request valid.
REQ-006 SHALL have port in_ready_o  output  1  block ready to accept operands.
REQ-007 SHALL have port dividend_i  input  WIDTH  unsigned dividend.
REQ-008 SHALL have port divisor_i  input  WIDTH  unsigned divisor.
REQ-009 SHALL have port mode_i  input  1  0 = floor quotient, 1 = ceiled quotient.
REQ-010 SHALL have port out_valid_o  output  1  result valid.
REQ-011 SHALL have port out_ready_i  input  1  consumer accepts result.
REQ-012 SHALL have port quotient_o  output  WIDTH  quotient, rounded per captured mode.
REQ-013 SHALL have port remainder_o  output  WIDTH  floor remainder (dividend mod divisor).
REQ-014 SHALL have port div_zero_o  output  1  result produced from a zero divisor.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, ADJ and DONE.
REQ-016 SHALL assert in_ready_o only in IDLE, so only one operation is in flight.
REQ-017 SHALL accept operands on in_valid_i && in_ready_o and capture dividend_i, divisor_i and the effective mode in the same edge.
REQ-018 SHALL ignore in_valid_i and operand changes while not in IDLE.
REQ-019 SHALL, on acceptance with divisor != 0, enter CALC and run a restoring radix-2 division: one quotient bit per cycle, MSB first, for exactly WIDTH cycles.
REQ-020 SHALL use an internal partial-remainder register of WIDTH+1 bits so the trial subtraction never overflows.
REQ-021 SHALL, after the last CALC cycle, spend one cycle in ADJ to apply rounding.
REQ-022 SHALL, in ADJ with ceil mode and remainder != 0, add 1 to the quotient; otherwise leave the quotient unchanged.
REQ-023 SHALL NOT need wrap-around handling for the ceil increment: a nonzero remainder implies divisor >= 2, so quotient <= (2^WIDTH-1)/2.
REQ-024 SHALL always present the floor remainder on remainder_o, independent of mode.
REQ-025 SHALL assert out_valid_o exactly WIDTH+1 cycles after the acceptance edge when divisor != 0.
REQ-026 SHALL, on acceptance with divisor == 0, go directly to DONE with:
- quotient_o = all ones
- remainder_o = dividend
- div_zero_o = 1
- out_valid_o asserted 1 cycle after acceptance.
REQ-027 SHALL clear div_zero_o for every accepted operation with a nonzero divisor.
REQ-028 SHALL, in DONE, hold out_valid_o, quotient_o, remainder_o and div_zero_o stable until out_valid_o && out_ready_i.
REQ-029 SHALL return to IDLE on the output handshake, with in_ready_o high in the next cycle.
REQ-030 SHALL, after the handshake, keep quotient_o, remainder_o and div_zero_o at their last values and deassert out_valid_o.
REQ-031 SHALL produce exact results for the boundary cases dividend = 0, divisor = 1, dividend < divisor and dividend = divisor = 2^WIDTH-1.

Reset
REQ-032 SHALL, while rst_i is high at a clock edge, force:
- state = IDLE
- out_valid_o = 0, div_zero_o = 0
- quotient_o = 0, remainder_o = 0
- all internal registers = 0.
REQ-033 SHALL drive in_ready_o = 1 in the first cycle after rst_i deasserts.
REQ-034 SHALL, when reset is asserted during CALC, ADJ or DONE, abort the operation and never emit a result for it.
REQ-035 SHALL let reset take priority over any simultaneous input or output handshake.

Verification (WIDTH=8)
REQ-036 SHALL cover: 7/2, mode=1 -> quotient 4, remainder 1, div_zero 0, out_valid 9 cycles after acceptance; same operands with mode=0 -> quotient 3.
REQ-037 SHALL cover: 10/5, mode=1 -> quotient 2, remainder 0 (no increment); 255/1, mode=1 -> quotient 255, remainder 0; 3/200, mode=1 -> quotient 1, remainder 3.
REQ-038 SHALL cover: 13/0 -> quotient 0xFF, remainder 13, div_zero 1, out_valid 1 cycle after acceptance; the next op 6/3 -> div_zero 0.
REQ-039 SHALL cover: out_ready_i held low 5 cycles in DONE while operands toggle -> outputs stable, in_ready_o = 0; after the handshake, in_ready_o = 1 in the next cycle.
REQ-040 SHALL cover: rst_i pulsed in the 4th CALC cycle of 200/7 -> all outputs 0, no out_valid_o; a fresh 200/7, mode=1 -> quotient 29, remainder 4.
REQ-041 SHALL cover: CEIL_EN=0 with 7/2, mode=1 -> quotient 3.
